// File: rtl/bram_stream_reader_if.sv
// Bundle for the RAM read port and the outgoing valid/ready word stream.
interface bram_stream_reader_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 18
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Reader side: drives the RAM address/enable and the stream source.
    modport master (
        output mem_addr,
        output mem_en,
        input  mem_rdata,
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Environment side: RAM port plus stream consumer.
    modport slave (
        input  mem_addr,
        input  mem_en,
        output mem_rdata,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read engine: drains a contiguous address range into a
// valid/ready stream, hiding the RAM's one-cycle read latency.
module bram_stream_reader #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                clka,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    bram_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d;
    logic [LEN_W-1:0]  accept_left_q, accept_left_d;
    logic              cap_q;
    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [DATA_W-1:0] skid0_q, skid0_d;
    logic [DATA_W-1:0] skid1_q, skid1_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;

    logic              hs;
    logic              load_head;
    logic [2:0]        pending;
    logic              credit_ok;

    // Stream head is a register fed from the 2-entry skid buffer (older
    // words) or directly from the RAM return when the buffer is empty.
    assign hs        = head_valid_q & bus.out_ready;
    assign load_head = (~head_valid_q | hs) & ((skid_cnt_q != 2'd0) | cap_q);

    // Words behind the head: read issued this cycle, read returning this
    // cycle, and buffered words. Keeping this at most 2 after the next issue
    // guarantees every return has a free buffer slot.
    assign pending   = 3'(mem_en_q) + 3'(cap_q) + 3'(skid_cnt_q);
    assign credit_ok = (pending - 3'(load_head)) < 3'd2;

    // Next-state, issue and transfer counters.
    always_comb begin
        state_d       = state_q;
        mem_en_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        issue_left_d  = issue_left_q;
        accept_left_d = accept_left_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (length != '0) begin
                        state_d       = ST_READ;
                        mem_en_d      = 1'b1;
                        mem_addr_d    = start_addr;
                        issue_left_d  = length - LEN_W'(1);
                        accept_left_d = length;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if ((issue_left_q != '0) && credit_ok) begin
                    mem_en_d     = 1'b1;
                    mem_addr_d   = mem_addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                end
                if (hs) begin
                    accept_left_d = accept_left_q - LEN_W'(1);
                    if (accept_left_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_READ);
        done_d = (state_d == ST_DONE);
    end

    // Head register and skid buffer update; returns are captured unconditionally.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        skid0_d      = skid0_q;
        skid1_d      = skid1_q;
        skid_cnt_d   = skid_cnt_q;

        if (~head_valid_q | hs) begin
            if (skid_cnt_q != 2'd0) begin
                head_valid_d = 1'b1;
                head_data_d  = skid0_q;
                skid0_d      = skid1_q;
                if (cap_q) begin
                    if (skid_cnt_q == 2'd1) begin
                        skid0_d = bus.mem_rdata;
                    end else begin
                        skid1_d = bus.mem_rdata;
                    end
                end else begin
                    skid_cnt_d = skid_cnt_q - 2'd1;
                end
            end else if (cap_q) begin
                head_valid_d = 1'b1;
                head_data_d  = bus.mem_rdata;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (cap_q) begin
            if (skid_cnt_q == 2'd0) begin
                skid0_d = bus.mem_rdata;
            end else begin
                skid1_d = bus.mem_rdata;
            end
            skid_cnt_d = skid_cnt_q + 2'd1;
        end
    end

    // State registers; reset also drops any read return due next cycle.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            issue_left_q  <= '0;
            accept_left_q <= '0;
            cap_q         <= 1'b0;
            head_valid_q  <= 1'b0;
            head_data_q   <= '0;
            skid0_q       <= '0;
            skid1_q       <= '0;
            skid_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            issue_left_q  <= issue_left_d;
            accept_left_q <= accept_left_d;
            cap_q         <= mem_en_q;
            head_valid_q  <= head_valid_d;
            head_data_q   <= head_data_d;
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
            skid_cnt_q    <= skid_cnt_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = head_valid_q;
    assign bus.out_data  = head_data_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural RAM, queue-based expected stream.
module tb_bram_stream_reader;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned LEN_W  = 16;

    logic              clka = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    bram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clka       (clka),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clka = ~clka;

    // Behavioural RAM port: one-cycle read latency.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clka) begin
        if (bus.mem_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    int    checks = 0;
    int    errors = 0;
    string cur_name;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=0x%0h expected=0x%0h", cur_name, tag, obs, exp);
        end
    endtask

    // Consumer ready: 0 = always, 1 = fixed 1,0,0,1,0,1 cycle, 2 = random.
    function automatic logic ready_for(input int mode, input int c);
        logic [5:0] pat;
        pat = 6'b101001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[c % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_xfer(input string name, input logic [ADDR_W-1:0] a, input int len,
                            input int mode, input int inj_cyc, input int rst_after);
        logic [DATA_W-1:0] expq[$];
        logic [DATA_W-1:0] prev_data;
        logic              prev_stall;
        logic              rdy;
        logic              rst_arm;
        int                issued;
        int                accepted;
        int                done_cyc;
        int                last_hs_cyc;
        int                exp_done;

        cur_name = name;
        for (int i = 0; i < len; i++) expq.push_back(ram[ADDR_W'(a + ADDR_W'(i))]);
        exp_done = (len == 0) ? 1 : len + 3;

        @(negedge clka);
        start         = 1'b1;
        start_addr    = a;
        length        = LEN_W'(len);
        rdy           = ready_for(mode, 0);
        bus.out_ready = rdy;
        issued = 0; accepted = 0; done_cyc = -1; last_hs_cyc = -1;
        prev_stall = 1'b0; prev_data = '0; rst_arm = 1'b0;

        for (int c = 1; c < 400 && done_cyc < 0; c++) begin
            @(negedge clka);
            start = (c == inj_cyc);
            if (c == inj_cyc) begin
                start_addr = a ^ ADDR_W'(16'h1234);
                length     = LEN_W'(len + 5);
            end
            rdy           = ready_for(mode, c);
            bus.out_ready = rdy;

            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'(1));
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.mem_en) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(ADDR_W'(a + ADDR_W'(issued))));
                issued++;
            end
            check("credit", 32'((issued - accepted - int'(bus.out_valid)) <= 2), 32'(1));
            if (mode == 0) begin
                check("t_mem_en", 32'(bus.mem_en), 32'(c <= len));
                check("t_valid", 32'(bus.out_valid), 32'(c >= 3 && c <= len + 2));
                check("t_done", 32'(done), 32'(c == exp_done));
                check("t_busy", 32'(busy), 32'(len != 0 && c <= len + 2));
            end

            if (rst_arm) begin
                reset = 1'b1;
                @(negedge clka);
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_done", 32'(done), 32'(0));
                check("rst_valid", 32'(bus.out_valid), 32'(0));
                check("rst_data", 32'(bus.out_data), 32'(0));
                check("rst_mem_en", 32'(bus.mem_en), 32'(0));
                check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
                reset = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clka);
                    check("post_rst_valid", 32'(bus.out_valid), 32'(0));
                    check("post_rst_mem_en", 32'(bus.mem_en), 32'(0));
                end
                return;
            end

            if (bus.out_valid && rdy) begin
                check("hs_in_range", 32'(accepted < len), 32'(1));
                if (accepted < len) check("data", 32'(bus.out_data), 32'(expq[accepted]));
                accepted++;
                last_hs_cyc = c;
                if (rst_after != 0 && accepted == rst_after) rst_arm = 1'b1;
            end
            prev_stall = bus.out_valid && !rdy;
            prev_data  = bus.out_data;
            if (done) done_cyc = c;
        end

        check("done_seen", 32'(done_cyc >= 0), 32'(1));
        check("done_cycle", 32'(done_cyc), 32'((len == 0) ? 1 : last_hs_cyc + 1));
        check("accepted", 32'(accepted), 32'(len));
        check("issued", 32'(issued), 32'(len));
        check("busy_in_done", 32'(busy), 32'(0));
        start = 1'b0;
        @(negedge clka);
        check("done_pulse", 32'(done), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        start_addr    = '0;
        length        = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
        ram[15'h0010] = 18'h2ABCD;
        for (int i = 0; i < 8; i++) ram[15'h0100 + i] = DATA_W'(i + 1);

        repeat (3) @(negedge clka);
        cur_name = "reset";
        check("busy", 32'(busy), 32'(0));
        check("done", 32'(done), 32'(0));
        check("out_valid", 32'(bus.out_valid), 32'(0));
        check("out_data", 32'(bus.out_data), 32'(0));
        check("mem_en", 32'(bus.mem_en), 32'(0));
        check("mem_addr", 32'(bus.mem_addr), 32'(0));
        reset = 1'b0;

        run_xfer("single",        15'h0010, 1, 0, 0, 0);
        run_xfer("burst8",        15'h0100, 8, 0, 0, 0);
        run_xfer("backpressure",  15'h0200, 6, 1, 0, 0);
        run_xfer("wrap4",         15'h7FFE, 4, 0, 0, 0);
        run_xfer("wrap_bp",       15'h7FFC, 7, 1, 0, 0);
        run_xfer("len0",          15'h0300, 0, 0, 0, 0);
        run_xfer("ignored_start", 15'h0400, 6, 1, 4, 0);
        run_xfer("ignored_full",  15'h0480, 5, 0, 2, 0);
        run_xfer("reset_mid",     15'h0500, 8, 0, 0, 3);
        run_xfer("after_reset",   15'h0000, 2, 0, 0, 0);
        run_xfer("single_again",  15'h0010, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            run_xfer("random", ADDR_W'($urandom), int'($urandom_range(1, 12)), 2, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
